// File: rtl/systolic_skew_feeder.sv
// -----------------------------------------------------------------------------
// systolic_skew_feeder
//
// Edge feeder for an N x N output-stationary systolic multiply array. Holds N
// rows of A (N x K) and N columns of B (K x N). During a run it drives the
// array's west edge (one A lane per row) and north edge (one B lane per
// column). Lane i is delayed by i cycles, so PE(i,j) sees A[i][k] and B[k][j]
// in the same cycle. Lanes are zero outside their data window. A one-cycle
// `done` pulse marks the point where every psum in the array is final.
// Assumes N >= 2.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   ld_valid/ready  buffer write handshake; ld_ready is high only in IDLE
//   ld_sel          0 = A buffer, 1 = B buffer
//   ld_lane, ld_k   row i (A) / column j (B), and inner index k
//   ld_data         operand written to the selected buffer word
//   start, k_len    run request and inner dimension, sampled in IDLE only
//   a_edge, b_edge  skewed lanes, lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
//   busy            run in progress (FEED or DRAIN)
//   done            one-cycle pulse, array psums are final
//   cfg_err         one-cycle pulse, start rejected because of k_len
// -----------------------------------------------------------------------------
module systolic_skew_feeder #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 16,
  parameter int K_MAX      = 16,
  parameter int KW         = $clog2(K_MAX + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ld_valid,
  output logic                    ld_ready,
  input  logic                    ld_sel,
  input  logic [$clog2(N)-1:0]    ld_lane,
  input  logic [$clog2(K_MAX)-1:0] ld_k,
  input  logic [DATA_WIDTH-1:0]   ld_data,
  input  logic                    start,
  input  logic [KW-1:0]           k_len,
  output logic [N*DATA_WIDTH-1:0] a_edge,
  output logic [N*DATA_WIDTH-1:0] b_edge,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err
);

  localparam int DW  = DATA_WIDTH;
  localparam int LW  = $clog2(N);
  localparam int KIW = $clog2(K_MAX);
  // t peaks at k_len + 2N - 2, which is below K_MAX + 2N.
  localparam int TW  = $clog2(K_MAX + 2 * N);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_e;

  state_e            state_q;
  logic [TW-1:0]     t_q;
  logic [KW-1:0]     klen_q;
  logic [N*DW-1:0]   a_edge_q, b_edge_q;
  logic              busy_q, done_q, cfg_err_q, ld_ready_q;

  logic [DW-1:0]     a_buf [N][K_MAX];
  logic [DW-1:0]     b_buf [N][K_MAX];

  logic              ld_k_ok, ld_fire, start_ok;
  logic [TW-1:0]     t_nxt, feed_last, drain_last;
  logic [KW-1:0]     klen_nxt;
  logic [N*DW-1:0]   a_edge_d, b_edge_d;

  // When K_MAX is a power of two every ld_k value addresses a real word.
  if ((1 << KIW) == K_MAX) begin : g_k_full
    assign ld_k_ok = 1'b1;
  end else begin : g_k_part
    assign ld_k_ok = (ld_k < KIW'(K_MAX));
  end

  assign ld_fire  = ld_valid && ld_ready_q && ld_k_ok;
  assign start_ok = (k_len != '0) && (k_len <= KW'(K_MAX));

  // NOTE: operand buffers carry no reset; every word is written before use,
  // and resetting a memory array would turn it into a large flop bank.
  always_ff @(posedge clk) begin
    if (ld_fire) begin
      if (ld_sel) b_buf[ld_lane][ld_k] <= ld_data;
      else        a_buf[ld_lane][ld_k] <= ld_data;
    end
  end

  // Word that lane `lane` carries at cycle t. A write landing on the same edge
  // as start is forwarded, so the run sees the updated buffer at t = 0.
  function automatic logic [DW-1:0] lane_word(input logic          sel,
                                              input logic [LW-1:0] lane,
                                              input logic [TW-1:0] t,
                                              input logic [KW-1:0] klen);
    int k;
    k = int'(t) - int'(lane);
    lane_word = '0;
    if (k >= 0 && k < int'(klen)) begin
      lane_word = sel ? b_buf[lane][KIW'(k)] : a_buf[lane][KIW'(k)];
      if (ld_fire && ld_sel == sel && ld_lane == lane && int'(ld_k) == k)
        lane_word = ld_data;
    end
  endfunction

  // Edge values for the cycle after the coming edge; registered below.
  // NOTE: every signal gets a default before any conditional assignment so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    t_nxt    = (state_q == S_IDLE) ? '0 : t_q + TW'(1);
    klen_nxt = (state_q == S_IDLE) ? k_len : klen_q;
    a_edge_d = '0;
    b_edge_d = '0;
    for (int i = 0; i < N; i++) begin
      a_edge_d[i*DW +: DW] = lane_word(1'b0, LW'(i), t_nxt, klen_nxt);
      b_edge_d[i*DW +: DW] = lane_word(1'b1, LW'(i), t_nxt, klen_nxt);
    end
  end

  // Lane N-1 carries its last word at t = k_len+N-2; the last product at
  // PE(N-1,N-1) is consumed at t = k_len+2N-3.
  assign feed_last  = TW'(klen_q) + TW'(N - 2);
  assign drain_last = TW'(klen_q) + TW'(2 * N - 3);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      t_q        <= '0;
      klen_q     <= '0;
      a_edge_q   <= '0;
      b_edge_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
      ld_ready_q <= 1'b1;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (start_ok) begin
              state_q    <= S_FEED;
              t_q        <= '0;
              klen_q     <= k_len;
              busy_q     <= 1'b1;
              ld_ready_q <= 1'b0;
              a_edge_q   <= a_edge_d;
              b_edge_q   <= b_edge_d;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        S_FEED: begin
          t_q <= t_nxt;
          if (t_q == feed_last) begin
            state_q  <= S_DRAIN;
            a_edge_q <= '0;
            b_edge_q <= '0;
          end else begin
            a_edge_q <= a_edge_d;
            b_edge_q <= b_edge_d;
          end
        end
        S_DRAIN: begin
          t_q <= t_nxt;
          if (t_q == drain_last) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q    <= S_IDLE;
          ld_ready_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign a_edge   = a_edge_q;
  assign b_edge   = b_edge_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign cfg_err  = cfg_err_q;
  assign ld_ready = ld_ready_q;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// -----------------------------------------------------------------------------
// tb_systolic_skew_feeder
//
// Directed and randomized bench for systolic_skew_feeder. Expected edge values
// come from the lane formula applied to bench-side copies of the buffers; a
// behavioural 4x4 PE array fed by the DUT edges is compared against plain
// matrix products.
// -----------------------------------------------------------------------------
module tb_systolic_skew_feeder;

  localparam int N     = 4;
  localparam int DW    = 16;
  localparam int K_MAX = 16;
  localparam int KW    = 5;
  localparam int EW    = N * DW;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          ld_valid = 1'b0;
  logic          ld_ready;
  logic          ld_sel   = 1'b0;
  logic [1:0]    ld_lane  = '0;
  logic [3:0]    ld_k     = '0;
  logic [DW-1:0] ld_data  = '0;
  logic          start    = 1'b0;
  logic [KW-1:0] k_len    = '0;
  logic [EW-1:0] a_edge, b_edge;
  logic          busy, done, cfg_err;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  logic [DW-1:0] ma [N][K_MAX];   // A[i][k]
  logic [DW-1:0] mb [N][K_MAX];   // B[k][j] stored as mb[j][k]
  logic [EW-1:0] snap_a, snap_b;

  systolic_skew_feeder #(
    .N(N), .DATA_WIDTH(DW), .K_MAX(K_MAX), .KW(KW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel),
    .ld_lane(ld_lane), .ld_k(ld_k), .ld_data(ld_data),
    .start(start), .k_len(k_len),
    .a_edge(a_edge), .b_edge(b_edge),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // Behavioural PE array: operands enter at the edges, move one PE east/south
  // per cycle, and each PE accumulates the product it sees.
  logic signed [DW-1:0] pe_a [N][N];
  logic signed [DW-1:0] pe_b [N][N];
  logic signed [47:0]   psum [N][N];

  function automatic logic signed [DW-1:0] west_in(input int i, input int j);
    if (j == 0) return $signed(a_edge[i*DW +: DW]);
    return pe_a[i][j-1];
  endfunction

  function automatic logic signed [DW-1:0] north_in(input int i, input int j);
    if (i == 0) return $signed(b_edge[j*DW +: DW]);
    return pe_b[i-1][j];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          pe_a[i][j] <= '0;
          pe_b[i][j] <= '0;
          psum[i][j] <= '0;
        end
    end else begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          psum[i][j] <= psum[i][j] + west_in(i, j) * north_in(i, j);
          pe_a[i][j] <= west_in(i, j);
          pe_b[i][j] <= north_in(i, j);
        end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Lane i carries buffer word t-i while 0 <= t-i < k_len, zero otherwise.
  function automatic logic [EW-1:0] exp_edge(input bit sel, input int t, input int kl);
    logic [EW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      int k;
      k = t - i;
      if (k >= 0 && k < kl) r[i*DW +: DW] = sel ? mb[i][k] : ma[i][k];
    end
    return r;
  endfunction

  task automatic load_word(input bit sel, input int lane, input int k, input logic [DW-1:0] d);
    ld_valid = 1'b1;
    ld_sel   = sel;
    ld_lane  = 2'(lane);
    ld_k     = 4'(k);
    ld_data  = d;
    @(posedge clk);
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic load_all();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K_MAX; k++) begin
        load_word(1'b0, i, k, ma[i][k]);
        load_word(1'b1, i, k, mb[i][k]);
      end
  endtask

  // Starts a run from IDLE (called at a negedge) and checks every cycle up to
  // and including the one after done. poke drives ignored start/load requests
  // mid-run; co_load writes A[0][0] in the same cycle as start.
  task automatic run_check(input int kl, input bit poke, input bit co_load,
                           input logic [DW-1:0] co_data);
    int last;
    last  = kl + 2 * N - 2;
    start = 1'b1;
    k_len = KW'(kl);
    if (co_load) begin
      ld_valid = 1'b1; ld_sel = 1'b0; ld_lane = '0; ld_k = '0; ld_data = co_data;
      ma[0][0] = co_data;
    end
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    ld_valid = 1'b0;
    for (int t = 0; t <= last; t++) begin
      check($sformatf("a_edge k%0d t%0d", kl, t), 64'(a_edge), 64'(exp_edge(1'b0, t, kl)));
      check($sformatf("b_edge k%0d t%0d", kl, t), 64'(b_edge), 64'(exp_edge(1'b1, t, kl)));
      check($sformatf("busy/done/rdy k%0d t%0d", kl, t), 64'({busy, done, ld_ready}),
            64'({t < last, t == last, 1'b0}));
      if (t == 3) begin
        snap_a = a_edge;
        snap_b = b_edge;
      end
      if (poke) begin
        ld_valid = (t == 1);
        ld_sel   = 1'b0;
        ld_lane  = '0;
        ld_k     = '0;
        ld_data  = ~ma[0][0];
        start    = (t == 2) || (t == last);
        k_len    = KW'(3);
      end
      @(negedge clk);
    end
    check($sformatf("post busy/done/rdy k%0d", kl), 64'({busy, done, ld_ready}), 64'(3'b001));
    check($sformatf("post edges k%0d", kl), 64'(a_edge | b_edge), 64'(0));
    start    = 1'b0;
    ld_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    // Reset values.
    repeat (2) @(negedge clk);
    check("reset a_edge", 64'(a_edge), 64'(0));
    check("reset b_edge", 64'(b_edge), 64'(0));
    check("reset busy/done/cfg_err/rdy", 64'({busy, done, cfg_err, ld_ready}), 64'(4'b0001));
    rst_n = 1'b1;
    @(negedge clk);

    // Directed skew pattern.
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K_MAX; k++) begin
        ma[i][k] = DW'(10 * i + k + 1);
        mb[i][k] = DW'(100 * i + k + 1);
      end
    load_all();
    run_check(4, 1'b0, 1'b0, '0);
    check("skew a t3", 64'(snap_a), {16'd31, 16'd22, 16'd13, 16'd4});
    check("skew b t3", 64'(snap_b), {16'd301, 16'd202, 16'd103, 16'd4});

    // Rejected starts.
    for (int e = 0; e < 2; e++) begin
      start = 1'b1;
      k_len = (e == 0) ? KW'(0) : KW'(17);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check($sformatf("cfg_err pulse %0d", e), 64'({cfg_err, busy, ld_ready}), 64'(3'b101));
      @(negedge clk);
      check($sformatf("cfg_err clear %0d", e), 64'({cfg_err, busy, done}), 64'(3'b000));
    end

    // Randomized runs, including k_len = 1 and 16, ignored inputs mid-run,
    // and a load coinciding with start.
    for (int r = 0; r < 6; r++) begin
      int kl;
      kl = (r == 0) ? 1 : (r == 1) ? K_MAX : int'($urandom_range(1, K_MAX));
      for (int i = 0; i < N; i++)
        for (int k = 0; k < K_MAX; k++) begin
          ma[i][k] = DW'($urandom);
          mb[i][k] = DW'($urandom);
        end
      load_all();
      run_check(kl, r == 2, r == 3, DW'($urandom));
      if (r == 2) run_check(kl, 1'b0, 1'b0, '0);
    end

    // End-to-end: A = I, B = ramp, k_len = 4 -> psum = B.
    pulse_reset();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K_MAX; k++) begin
        ma[i][k] = (i == k) ? DW'(1) : DW'(0);
        mb[i][k] = DW'(k * N + i + 1);
      end
    load_all();
    run_check(4, 1'b0, 1'b0, '0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        check($sformatf("identity psum %0d%0d", i, j), 64'(psum[i][j]), 64'(i * N + j + 1));

    // End-to-end: random signed A and B, k_len = 16 -> psum = A*B.
    pulse_reset();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K_MAX; k++) begin
        ma[i][k] = DW'($urandom);
        mb[i][k] = DW'($urandom);
      end
    load_all();
    run_check(K_MAX, 1'b0, 1'b0, '0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        longint acc;
        acc = 0;
        for (int k = 0; k < K_MAX; k++)
          acc += longint'($signed(ma[i][k])) * longint'($signed(mb[j][k]));
        check($sformatf("product psum %0d%0d", i, j), 64'(psum[i][j]), acc);
      end

    // Asynchronous reset in the middle of FEED.
    start = 1'b1;
    k_len = KW'(8);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre-reset a_edge t2", 64'(a_edge), 64'(exp_edge(1'b0, 2, 8)));
    check("pre-reset busy", 64'(busy), 64'(1));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async reset edges", 64'(a_edge | b_edge), 64'(0));
    check("async reset busy/done", 64'({busy, done}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after reset ld_ready", 64'(ld_ready), 64'(1));
    for (int c = 0; c < 20; c++) begin
      check($sformatf("no done after reset c%0d", c), 64'({busy, done}), 64'(0));
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Edge feeder for the N×N output-stationary systolic multiply array. It buffers N rows of matrix A (N×K) and N columns of matrix B (K×N), then drives the array's west edge (A lanes, one per row) and north edge (B lanes, one per column). Lane i is delayed by i cycles (diagonal skew), so PE(i,j) sees A[i][k] and B[k][j] in the same cycle. Lanes are zero-filled outside their data window; PEs skip zero operands, so zero-fill cycles are idle. After the last operand has reached PE(N-1,N-1), the block pulses `done` to signal that every `psum` in the array is final.

## Interface
- N, 4, array dimension (lanes per edge)
- DATA_WIDTH, 16, operand width (signed)
- K_MAX, 16, maximum inner dimension; buffer depth per lane
- KW, $clog2(K_MAX+1), width of k_len
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ld_valid  in  1  buffer write strobe
- ld_ready  out  1  high only in IDLE; a write takes effect when ld_valid && ld_ready
- ld_sel  in  1  0 = A buffer, 1 = B buffer
- ld_lane  in  $clog2(N)  row i (A) or column j (B)
- ld_k  in  $clog2(K_MAX)  inner index k
- ld_data  in  DATA_WIDTH  operand value
- start  in  1  run request, sampled in IDLE only
- k_len  in  KW  inner dimension for this run, sampled with start
- a_edge  out  N*DATA_WIDTH  lane i at bits [i*DW +: DW] → A_in of PE(i,0)
- b_edge  out  N*DATA_WIDTH  lane j at bits [j*DW +: DW] → B_in of PE(0,j)
- busy  out  1  run in progress (FEED or DRAIN)
- done  out  1  one-cycle pulse; array psums are final
- cfg_err  out  1  one-cycle pulse; start rejected because of k_len

## Operation
- Buffers: A_buf[i][k] and B_buf[j][k], no reset. ld_k ≥ K_MAX is a no-op.
- States:
  - IDLE: accepts start and loads.
  - FEED: lasts k_len+N-1 cycles.
  - DRAIN: lasts N-1 cycles.
  - DONE: lasts 1 cycle.
- Transitions:
  - IDLE→FEED on start with 1 ≤ k_len ≤ K_MAX. k_len is latched.
  - start with k_len = 0 or k_len > K_MAX: stay in IDLE; pulse cfg_err on the next cycle.
  - FEED→DRAIN when t = k_len+N-2. DRAIN→DONE when t = k_len+2N-3. DONE→IDLE unconditionally.
- t is a cycle counter that is 0 in the first FEED cycle and increments every cycle through FEED and DRAIN.
- FEED outputs:
  - a_edge lane i = A_buf[i][t-i] if 0 ≤ t-i < k_len, else 0.
  - b_edge lane j = B_buf[j][t-j] if 0 ≤ t-j < k_len, else 0.
- DRAIN, DONE and IDLE: a_edge = b_edge = 0.
- Ignored inputs:
  - start in any state other than IDLE (includes the DONE cycle).
  - ld_valid while ld_ready = 0.
  - A load and a start in the same IDLE cycle: the write completes, and the run uses the updated buffer.
- The block does not clear PE accumulators. Clearing between runs is the integrator's job, by rst_n pulse.

## Timing
- All outputs are registered.
- Reset values: a_edge = 0, b_edge = 0, busy = 0, done = 0, cfg_err = 0, ld_ready = 1 (state IDLE).
- start sampled on edge E:
  - Cycle after E is t = 0: busy = 1, ld_ready = 0, lane-0 data is A_buf[0][0] / B_buf[0][0].
  - Lane i first carries nonzero data at t = i and last carries data at t = k_len-1+i.
- PE(i,j) consumes A[i][k] at t = k+i+j. The last product, at PE(N-1,N-1), is consumed at t = k_len+2N-3.
- done = 1 and busy = 0 at t = k_len+2N-2, so start-to-done latency is k_len+2N-1 edges. ld_ready returns to 1 one cycle after done.
- cfg_err asserts on the cycle after the rejected start.
- rst_n assert mid-run: all outputs go to their reset values immediately (asynchronous), state returns to IDLE, no done pulse. Buffer contents are unspecified afterwards.

## Test plan
- **Reset:** assert rst_n mid-FEED → a_edge, b_edge, busy and done are 0 in the same cycle; ld_ready = 1 after release.
- **Skew pattern:** N=4, k_len=4, A_buf[i][k] = 10i+k+1, B_buf[j][k] = 100j+k+1.
  - Check each lane equals the formula for t = 0..6, e.g. at t=3: a_edge = {A[3][0]=31, A[2][1]=22, A[1][2]=13, A[0][3]=4}.
  - Check both edges are 0 for t = 7..9.
  - Check done at t = 10, exactly one cycle.
- **End-to-end:** feeder plus 4×4 PE array, A = I, B = a ramp matrix → every psum equals B after done; random signed A and B with k_len = 16 → psum equals A·B.
- **Config errors:** start with k_len = 0, then with k_len = 17 → cfg_err pulses once each, busy stays 0, no done.
- **Ignored inputs:** start during FEED and during the DONE cycle → ignored, done timing unchanged. ld_valid during a run → buffer unchanged, verified by a second run.
- **Minimum run:** k_len = 1 → lane i is nonzero only at t = i; done at t = 7.
